ir_axil_cfg_sequencer: RTL and testbench
========================================

// Module: ir_axil_cfg_sequencer
// PURPOSE
//  AXI4-Lite master that runs the IR peripheral's register write/readback sequence in hardware.
//  Sits between the PS/boot logic and the IR_v1_2 S00_AXI slave.
//  On start: writes NUM_REGS words to consecutive registers, reads each back, compares, reports pass/fail.
//  Used for power-on configuration and built-in self-test of the IR register file.
// PARAMETERS
//  C_M_AXI_ADDR_WIDTH  32        AXI address width
//  C_M_AXI_DATA_WIDTH  32        AXI data width (only 32 supported)
//  C_BASE_ADDR         32'h0     address of register 0; register i at C_BASE_ADDR + 4*i
//  C_NUM_REGS          4         registers in sequence, 1..16
//  C_TIMEOUT           255       max cycles waiting on any single handshake, >=1
// PORTS
//  ACLK           in   1        clock; all logic on rising edge
//  ARESET         in   1        synchronous, active-high reset
//  start          in   1        one-cycle request; honoured only in IDLE
//  cfg_data       in   32*N     word i = cfg_data[32*i+:32]; sampled per write, hold stable while busy
//  busy           out  1        high from the cycle after accepted start until done
//  done           out  1        one-cycle pulse at sequence end (pass or fail)
//  pass           out  1        valid with done, held until next accepted start
//  err_code       out  2        0 none, 1 bad BRESP/RRESP, 2 data mismatch, 3 timeout
//  err_idx        out  4        register index of the first failure
//  M_AXI_AW*      AWADDR, AWPROT(=3'b000), AWVALID out; AWREADY in
//  M_AXI_W*       WDATA, WSTRB(=4'hF), WVALID out; WREADY in
//  M_AXI_B*       BRESP, BVALID in; BREADY out
//  M_AXI_AR*      ARADDR, ARPROT(=3'b000), ARVALID out; ARREADY in
//  M_AXI_R*       RDATA, RRESP, RVALID in; RREADY out
// BEHAVIOUR
//  Reset: every output 0 (all VALID/READY low, busy/done/pass 0, err 0); FSM IDLE; idx 0.
//  Reset mid-sequence: same values the next cycle; outstanding transaction abandoned.
//  FSM: IDLE -> WR -> WR_RESP -> RD -> RD_RESP -> CHECK -> (idx<N-1 ? WR : FIN) -> IDLE.
//  IDLE: start=1 -> idx=0, clear pass/err, busy=1, go WR; start in any other state ignored.
//  WR: AWVALID and WVALID rise together the cycle after entry, same address/data.
//    Each VALID drops the cycle after its own READY is seen; AW and W complete independently.
//    Leave WR once both are done.
//  WR_RESP: BREADY=1; on BVALID: BRESP!=OKAY -> err 1, go FIN; else go RD.
//  RD: ARVALID with ARADDR = C_BASE_ADDR+4*idx until ARREADY.
//  RD_RESP: RREADY=1; on RVALID capture RDATA; RRESP!=OKAY -> err 1, FIN; else CHECK.
//  CHECK: one cycle; RDATA!=cfg_data[idx] -> err 2, FIN; else idx++ or FIN at last index.
//  Address arithmetic wraps modulo 2^C_M_AXI_ADDR_WIDTH; no overflow check.
//  Timeout:
//    - Counter clears on every state entry and increments while the awaited READY/VALID is absent.
//    - Reaching C_TIMEOUT -> err 3, all VALID/READY drop, go FIN.
//    - Deliberate fault-recovery deviation from AXI.
//  READY and VALID present on the cycle VALID rises: handshake completes that cycle.
//  No pipelining: one transaction outstanding.
//  FIN: done=1, busy=0, pass=(err_code==0), err_idx=failing idx; next cycle IDLE.
//  Minimum latency, zero-wait slave: 6 cycles per register + 1 for FIN.
// STRUCTURE
//  ir_seq_defs.vh: FSM state localparams, ERR_* codes, RESP_OKAY=2'b00.
//  Sub-module ir_seq_timer: loadable down-counter, clear/enable in, expired out; reused per handshake.
//  Top: FSM, index, address/data muxing, compare.
// TESTING
//  T1: zero-wait slave, N=4, data {0101FFFF, abcd0001, dead0011, beef0011}
//      -> 4 writes/4 reads at 0x0,0x4,0x8,0xC; done after 25 cycles; pass=1.
//  T2: slave returns RDATA=0 on reg 2 -> done, pass=0, err_code=2, err_idx=2; no access to 0xC.
//  T3: BRESP=SLVERR on reg 1 write -> err_code=1, err_idx=1; no AR issued for reg 1.
//  T4: AWREADY held low (C_TIMEOUT=16) -> AWVALID drops after 16 cycles; err_code=3, err_idx=0.
//  T5: WREADY 3 cycles before AWREADY, start pulsed while busy
//      -> independent VALID drop, second start ignored, pass=1.
//  T6: ARESET asserted mid RD_RESP -> next cycle all outputs 0; new start runs clean to pass=1.

Source files
------------

// File: rtl/ir_axil_cfg_sequencer_pkg.sv
// Shared constants for the IR register write/readback sequencer:
// FSM state encodings, error codes and the AXI OKAY response.
`timescale 1ns/1ps
package ir_axil_cfg_sequencer_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR      = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD      = 3'd3;
    localparam logic [2:0] S_RD_RESP = 3'd4;
    localparam logic [2:0] S_CHECK   = 3'd5;
    localparam logic [2:0] S_FIN     = 3'd6;

    typedef logic [1:0] err_t;

    localparam err_t ERR_NONE     = 2'd0;
    localparam err_t ERR_RESP     = 2'd1;
    localparam err_t ERR_MISMATCH = 2'd2;
    localparam err_t ERR_TIMEOUT  = 2'd3;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    function automatic logic resp_ok(input logic [1:0] resp);
        return resp == RESP_OKAY;
    endfunction

endpackage

// File: rtl/ir_axil_cfg_sequencer_timer.sv
// Handshake watchdog: down-counter reloaded on every FSM state change,
// decremented while the awaited READY/VALID is absent. 'expired' fires on
// the C_TIMEOUT-th absent cycle since the last reload.
`timescale 1ns/1ps
module ir_axil_cfg_sequencer_timer #(
    parameter int C_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int TW = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT) : 1;
    localparam logic [TW-1:0] LOAD = TW'(C_TIMEOUT - 1);

    logic [TW-1:0] cnt;

    // Reload on reset/clear, otherwise count down while waiting, saturating at zero.
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= LOAD;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expired = en && (cnt == '0);

endmodule

// File: rtl/ir_axil_cfg_sequencer.sv
// AXI4-Lite master that writes C_NUM_REGS config words to consecutive
// registers of the IR peripheral, reads each back, compares, and reports
// pass/fail with the first failing index and an error code.
`timescale 1ns/1ps
module ir_axil_cfg_sequencer
    import ir_axil_cfg_sequencer_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0,
    parameter int C_NUM_REGS = 4,
    parameter int C_TIMEOUT = 255
) (
    input  logic                                     ACLK,
    input  logic                                     ARESET,
    input  logic                                     start,
    input  logic [C_M_AXI_DATA_WIDTH*C_NUM_REGS-1:0] cfg_data,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     pass,
    output logic [1:0]                               err_code,
    output logic [3:0]                               err_idx,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]            M_AXI_AWADDR,
    output logic [2:0]                               M_AXI_AWPROT,
    output logic                                     M_AXI_AWVALID,
    input  logic                                     M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]            M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]          M_AXI_WSTRB,
    output logic                                     M_AXI_WVALID,
    input  logic                                     M_AXI_WREADY,
    input  logic [1:0]                               M_AXI_BRESP,
    input  logic                                     M_AXI_BVALID,
    output logic                                     M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]            M_AXI_ARADDR,
    output logic [2:0]                               M_AXI_ARPROT,
    output logic                                     M_AXI_ARVALID,
    input  logic                                     M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]            M_AXI_RDATA,
    input  logic [1:0]                               M_AXI_RRESP,
    input  logic                                     M_AXI_RVALID,
    output logic                                     M_AXI_RREADY
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;

    logic [2:0]    state, state_nxt;
    logic [3:0]    idx;
    err_t          err_nxt;
    logic          aw_vld, w_vld, aw_done, w_done, wr_issued;
    logic          aw_hs, w_hs, aw_fin, w_fin, last;
    logic          tmr_en, tmr_exp;
    logic [DW-1:0] rdata_q, cfg_word;
    logic [AW-1:0] reg_addr;

    assign aw_hs  = aw_vld && M_AXI_AWREADY;
    assign w_hs   = w_vld && M_AXI_WREADY;
    assign aw_fin = aw_done || aw_hs;
    assign w_fin  = w_done || w_hs;
    assign last   = (idx == 4'(C_NUM_REGS - 1));

    // Select the config word for the current register index.
    always_comb begin
        cfg_word = '0;
        for (int i = 0; i < C_NUM_REGS; i++)
            if (idx == 4'(i))
                cfg_word = cfg_data[DW*i +: DW];
    end

    // Timer runs only while the handshake this state is waiting on is missing.
    always_comb begin
        tmr_en = 1'b0;
        case (state)
            S_WR:      tmr_en = wr_issued && !(aw_fin && w_fin);
            S_WR_RESP: tmr_en = !M_AXI_BVALID;
            S_RD:      tmr_en = !M_AXI_ARREADY;
            S_RD_RESP: tmr_en = !M_AXI_RVALID;
            default:   tmr_en = 1'b0;
        endcase
    end

    ir_axil_cfg_sequencer_timer #(.C_TIMEOUT(C_TIMEOUT)) u_timer (
        .clk     (ACLK),
        .rst     (ARESET),
        .clr     (state_nxt != state),
        .en      (tmr_en),
        .expired (tmr_exp)
    );

    // Next-state and error classification for the transition out of this cycle.
    always_comb begin
        state_nxt = state;
        err_nxt   = ERR_NONE;
        case (state)
            S_IDLE: if (start) state_nxt = S_WR;
            S_WR:
                if (wr_issued) begin
                    if (aw_fin && w_fin)
                        state_nxt = S_WR_RESP;
                    else if (tmr_exp) begin
                        err_nxt = ERR_TIMEOUT; state_nxt = S_FIN;
                    end
                end
            S_WR_RESP:
                if (M_AXI_BVALID) begin
                    if (resp_ok(M_AXI_BRESP)) state_nxt = S_RD;
                    else begin err_nxt = ERR_RESP; state_nxt = S_FIN; end
                end else if (tmr_exp) begin
                    err_nxt = ERR_TIMEOUT; state_nxt = S_FIN;
                end
            S_RD:
                if (M_AXI_ARREADY) state_nxt = S_RD_RESP;
                else if (tmr_exp) begin err_nxt = ERR_TIMEOUT; state_nxt = S_FIN; end
            S_RD_RESP:
                if (M_AXI_RVALID) begin
                    if (resp_ok(M_AXI_RRESP)) state_nxt = S_CHECK;
                    else begin err_nxt = ERR_RESP; state_nxt = S_FIN; end
                end else if (tmr_exp) begin
                    err_nxt = ERR_TIMEOUT; state_nxt = S_FIN;
                end
            S_CHECK:
                if (rdata_q != cfg_word) begin err_nxt = ERR_MISMATCH; state_nxt = S_FIN; end
                else state_nxt = last ? S_FIN : S_WR;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM state, index, write-channel valids, readback capture and result registers.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= S_IDLE;
            idx       <= '0;
            aw_vld    <= 1'b0;
            w_vld     <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            wr_issued <= 1'b0;
            rdata_q   <= '0;
            pass      <= 1'b0;
            err_code  <= ERR_NONE;
            err_idx   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE:
                    if (start) begin
                        idx      <= '0;
                        pass     <= 1'b0;
                        err_code <= ERR_NONE;
                        err_idx  <= '0;
                    end
                S_WR:
                    // First WR cycle raises both valids; afterwards each drops on its own handshake.
                    if (!wr_issued) begin
                        aw_vld    <= 1'b1;
                        w_vld     <= 1'b1;
                        wr_issued <= 1'b1;
                    end else begin
                        if (aw_hs) begin aw_vld <= 1'b0; aw_done <= 1'b1; end
                        if (w_hs)  begin w_vld  <= 1'b0; w_done  <= 1'b1; end
                    end
                S_RD_RESP: if (M_AXI_RVALID) rdata_q <= M_AXI_RDATA;
                S_CHECK:   if (state_nxt == S_WR) idx <= idx + 1'b1;
                default: ;
            endcase
            // Any state change (including a timeout abort) drops the write valids.
            if (state_nxt != state) begin
                aw_vld    <= 1'b0;
                w_vld     <= 1'b0;
                aw_done   <= 1'b0;
                w_done    <= 1'b0;
                wr_issued <= 1'b0;
            end
            if (state_nxt == S_FIN) begin
                pass <= (err_nxt == ERR_NONE);
                if (err_nxt != ERR_NONE) begin
                    err_code <= err_nxt;
                    err_idx  <= idx;
                end
            end
        end
    end

    assign reg_addr = C_BASE_ADDR + (AW'(idx) << 2);

    assign busy          = (state != S_IDLE) && (state != S_FIN);
    assign done          = (state == S_FIN);
    assign M_AXI_AWADDR  = busy ? reg_addr : '0;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = aw_vld;
    assign M_AXI_WDATA   = busy ? cfg_word : '0;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = w_vld;
    assign M_AXI_BREADY  = (state == S_WR_RESP);
    assign M_AXI_ARADDR  = busy ? reg_addr : '0;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = (state == S_RD);
    assign M_AXI_RREADY  = (state == S_RD_RESP);

endmodule

// File: tb/tb_ir_axil_cfg_sequencer.sv
// Bench for ir_axil_cfg_sequencer: behavioural AXI4-Lite slave with
// per-test stalls/faults, a scoreboard of expected AW/W/AR beats, a table of
// sequence scenarios and a hand-written mid-sequence reset case.
`timescale 1ns/1ps
module tb_ir_axil_cfg_sequencer;

    localparam int N = 4;

    logic         ACLK = 1'b0;
    logic         ARESET, start;
    logic [32*N-1:0] cfg_data;
    logic         busy, done, pass;
    logic [1:0]   err_code;
    logic [3:0]   err_idx;
    logic [31:0]  M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
    logic [2:0]   M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]   M_AXI_WSTRB;
    logic [1:0]   M_AXI_BRESP, M_AXI_RRESP;
    logic         M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic         M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic         M_AXI_RVALID, M_AXI_RREADY;

    ir_axil_cfg_sequencer #(
        .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .C_BASE_ADDR(32'h0),
        .C_NUM_REGS(N), .C_TIMEOUT(16)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start), .cfg_data(cfg_data),
        .busy(busy), .done(done), .pass(pass), .err_code(err_code), .err_idx(err_idx),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    // Scenario record: slave behaviour, scoreboard depths, expected results.
    typedef struct {
        logic [32*N-1:0] data;
        int aw_delay; int w_delay; bit aw_stall; int bad_b; int bad_r; int restart_at;
        int n_aw; int n_w; int n_ar;
        bit exp_pass; int exp_err; int exp_idx; int exp_cyc; int exp_awv; int exp_indep;
    } vec_t;

    vec_t vecs[5];

    int n_total = 0, n_pass = 0;

    // Slave configuration and state (all driven from the single test process).
    int aw_delay, w_delay, bad_b, bad_r;
    bit aw_stall, sb_en;
    int aw_cnt, w_cnt, wr_reg, rd_reg;
    bit aw_have, w_have, b_pend, r_pend;
    bit s_aw, s_w, s_b, s_ar, s_r;
    logic [31:0] snap_awaddr, snap_wdata, snap_araddr, aw_q, w_q;
    logic [31:0] mem [4];
    int awv_total = 0, indep_total = 0;

    logic [31:0] exp_aw[$], exp_w[$], exp_ar[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    endtask

    task automatic fail1(input string nm, input logic [31:0] act);
        n_total++;
        $display("FAIL %s: got %0h, want no beat", nm, act);
    endtask

    task automatic slave_clear();
        aw_cnt = 0; w_cnt = 0; wr_reg = 0; rd_reg = 0;
        aw_have = 0; w_have = 0; b_pend = 0; r_pend = 0;
        s_aw = 0; s_w = 0; s_b = 0; s_ar = 0; s_r = 0;
        snap_awaddr = 0; snap_wdata = 0; snap_araddr = 0; aw_q = 0; w_q = 0;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
        M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
    endtask

    // One slave step per negedge: retire beats that completed at the last
    // posedge, then set up slave outputs for the next posedge.
    task automatic slave_step();
        if (ARESET) begin slave_clear(); return; end
        if (s_aw) begin
            if (sb_en) begin
                if (exp_aw.size() == 0) fail1("aw_unexpected", snap_awaddr);
                else chk("aw_addr", snap_awaddr, exp_aw.pop_front());
            end
            aw_q = snap_awaddr; aw_have = 1;
        end
        if (s_w) begin
            if (sb_en) begin
                if (exp_w.size() == 0) fail1("w_unexpected", snap_wdata);
                else chk("w_data", snap_wdata, exp_w.pop_front());
            end
            w_q = snap_wdata; w_have = 1;
        end
        if (aw_have && w_have) begin
            wr_reg = int'(aw_q[3:2]); mem[wr_reg] = w_q; b_pend = 1;
            aw_have = 0; w_have = 0;
        end
        if (s_b) b_pend = 0;
        if (s_ar) begin
            if (sb_en) begin
                if (exp_ar.size() == 0) fail1("ar_unexpected", snap_araddr);
                else chk("ar_addr", snap_araddr, exp_ar.pop_front());
            end
            rd_reg = int'(snap_araddr[3:2]); r_pend = 1;
        end
        if (s_r) r_pend = 0;

        aw_cnt = M_AXI_AWVALID ? aw_cnt + 1 : 0;
        w_cnt  = M_AXI_WVALID ? w_cnt + 1 : 0;
        M_AXI_AWREADY = M_AXI_AWVALID && !aw_stall && (aw_cnt > aw_delay);
        M_AXI_WREADY  = M_AXI_WVALID && (w_cnt > w_delay);
        M_AXI_BVALID  = b_pend;
        M_AXI_BRESP   = (wr_reg == bad_b) ? 2'b10 : 2'b00;
        M_AXI_ARREADY = M_AXI_ARVALID;
        M_AXI_RVALID  = r_pend;
        M_AXI_RDATA   = (rd_reg == bad_r) ? 32'h0 : mem[rd_reg];
        M_AXI_RRESP   = 2'b00;

        s_aw = M_AXI_AWVALID && M_AXI_AWREADY; snap_awaddr = M_AXI_AWADDR;
        s_w  = M_AXI_WVALID && M_AXI_WREADY;   snap_wdata  = M_AXI_WDATA;
        s_b  = M_AXI_BVALID && M_AXI_BREADY;
        s_ar = M_AXI_ARVALID && M_AXI_ARREADY; snap_araddr = M_AXI_ARADDR;
        s_r  = M_AXI_RVALID && M_AXI_RREADY;
        if (M_AXI_AWVALID) awv_total++;
        if (M_AXI_AWVALID && !M_AXI_WVALID) indep_total++;
    endtask

    task automatic cycle();
        @(negedge ACLK);
        slave_step();
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n, awv0, ind0;
        slave_clear();
        exp_aw.delete(); exp_w.delete(); exp_ar.delete();
        cfg_data = v.data; aw_delay = v.aw_delay; w_delay = v.w_delay;
        aw_stall = v.aw_stall; bad_b = v.bad_b; bad_r = v.bad_r;
        for (int i = 0; i < v.n_aw; i++) exp_aw.push_back(32'(4 * i));
        for (int i = 0; i < v.n_w; i++)  exp_w.push_back(v.data[32*i +: 32]);
        for (int i = 0; i < v.n_ar; i++) exp_ar.push_back(32'(4 * i));
        awv0 = awv_total; ind0 = indep_total;
        start = 1'b1;
        cycle();
        start = 1'b0;
        n = 1;
        chk({tag, "_busy_after_start"}, busy, 1);
        while (!done && n < 300) begin
            start = (n == v.restart_at);
            cycle();
            n++;
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, done, 1);
        chk({tag, "_latency"}, n, v.exp_cyc);
        chk({tag, "_pass"}, pass, v.exp_pass);
        chk({tag, "_err_code"}, err_code, v.exp_err);
        chk({tag, "_err_idx"}, err_idx, v.exp_idx);
        chk({tag, "_busy_in_fin"}, busy, 0);
        cycle();
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_pass_held"}, pass, v.exp_pass);
        cycle();
        chk({tag, "_stays_idle"}, busy, 0);
        chk({tag, "_awvalid_cycles"}, awv_total - awv0, v.exp_awv);
        chk({tag, "_aw_only_cycles"}, indep_total - ind0, v.exp_indep);
        chk({tag, "_sb_left"}, exp_aw.size() + exp_w.size() + exp_ar.size(), 0);
    endtask

    function automatic logic [127:0] outs_vec();
        return {busy, done, pass, err_code, err_idx, M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
                M_AXI_WDATA, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARPROT, M_AXI_ARVALID, M_AXI_RREADY};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rr, k;
        // data, awd, wd, stall, bad_b, bad_r, restart, n_aw, n_w, n_ar, pass, err, idx, cyc, awv, indep
        vecs[0] = '{{32'hbeef0011, 32'hdead0011, 32'habcd0001, 32'h0101ffff},
                    0, 0, 1'b0, -1, -1, -1, 4, 4, 4, 1'b1, 0, 0, 25, 4, 0};
        vecs[1] = '{{32'h12345678, 32'h9abcdef0, 32'h0f0f0f0f, 32'hf0f0f0f0},
                    0, 0, 1'b0, -1, 2, -1, 3, 3, 3, 1'b0, 2, 2, 19, 3, 0};
        vecs[2] = '{{32'ha5a5a5a5, 32'h5a5a5a5a, 32'h00000001, 32'h80000000},
                    0, 0, 1'b0, 1, -1, -1, 2, 2, 1, 1'b0, 1, 1, 10, 2, 0};
        vecs[3] = '{{32'hbeef0011, 32'hdead0011, 32'habcd0001, 32'h0101ffff},
                    0, 0, 1'b1, -1, -1, -1, 0, 1, 0, 1'b0, 3, 0, 18, 16, 15};
        vecs[4] = '{{32'hcafef00d, 32'h13579bdf, 32'h2468ace0, 32'h0badc0de},
                    3, 0, 1'b0, -1, -1, 5, 4, 4, 4, 1'b1, 0, 0, 37, 16, 12};

        ARESET = 1'b1; start = 1'b0; cfg_data = '0; sb_en = 1'b1;
        aw_delay = 0; w_delay = 0; aw_stall = 0; bad_b = -1; bad_r = -1;
        for (int i = 0; i < 4; i++) mem[i] = 32'h0;
        slave_clear();
        repeat (3) cycle();
        chk("reset_outputs", outs_vec(), 0);
        chk("reset_wstrb", M_AXI_WSTRB, 4'hf);
        ARESET = 1'b0;
        cycle();

        for (int t = 0; t < 5; t++) run_vec(vecs[t], $sformatf("T%0d", t + 1));

        // Reset while waiting for the readback of register 1.
        sb_en = 1'b0;
        slave_clear();
        cfg_data = vecs[0].data; aw_delay = 0; w_delay = 0; aw_stall = 0; bad_b = -1; bad_r = -1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        rr = 0; k = 0;
        while (rr < 2 && k < 100) begin
            if (M_AXI_RREADY) rr++;
            if (rr < 2) begin cycle(); k++; end
        end
        chk("T6_reached_rd_resp", rr, 2);
        ARESET = 1'b1;
        cycle();
        chk("T6_outputs_after_reset", outs_vec(), 0);
        ARESET = 1'b0;
        cycle();
        chk("T6_idle_after_reset", busy, 0);
        sb_en = 1'b1;
        run_vec(vecs[0], "T6_rerun");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
